// File: rtl/strb_upsize_mask_accum.sv
// Write-strobe upsizer: steers narrow strobe beats into their byte-lane slot
// of a wide bus, OR-accumulates them into one wide strobe word, and emits the
// word with its per-bit expanded data mask through a registered valid/ready
// output stage.
module strb_upsize_mask_accum #(
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 64,
  localparam int SIN   = DATA_WIDTH_IN / 8,
  localparam int SOUT  = DATA_WIDTH_OUT / 8,
  localparam int OFS_W = (SOUT > 1) ? $clog2(SOUT) : 1
) (
  input  logic                      ACLK,
  input  logic                      sysReset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIN-1:0]            in_strb,
  input  logic [OFS_W-1:0]          in_addr_lo,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SOUT-1:0]           out_strb,
  output logic [DATA_WIDTH_OUT-1:0] out_mask_bit,
  output logic                      out_last
);

  localparam int RATIO = DATA_WIDTH_OUT / DATA_WIDTH_IN;
  localparam int LO_W  = $clog2(SIN);
  localparam logic [OFS_W-1:0] LAST_SLOT = OFS_W'(RATIO - 1);

  // Replicate every byte strobe across the eight data bits it qualifies.
  function automatic logic [DATA_WIDTH_OUT-1:0] expand_mask(input logic [SOUT-1:0] strb);
    logic [DATA_WIDTH_OUT-1:0] mask;
    mask = {DATA_WIDTH_OUT{1'b0}};
    for (int i = 0; i < SOUT; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  logic [SOUT-1:0]  acc_r;
  logic [OFS_W-1:0] slot_s;
  logic [SOUT-1:0]  lane_base_s;
  logic [SOUT-1:0]  lane_strb_s;
  logic [SOUT-1:0]  merged_s;
  logic             accept_s;
  logic             closing_s;

  // Upstream may push whenever the output register is empty or draining.
  assign in_ready = ~sysReset & (~out_valid | out_ready);
  assign accept_s = in_valid & in_ready;

  // Slot index from the address bits above the narrow-beat byte offset.
  always_comb begin
    slot_s = {OFS_W{1'b0}};
    if (RATIO == 1) begin
      slot_s = {OFS_W{1'b0}};
    end else begin
      slot_s = in_addr_lo >> LO_W;
    end
  end

  // Steer the narrow strobes to their lane and merge with the partial word.
  always_comb begin
    lane_base_s = {SOUT{1'b0}};
    lane_base_s[SIN-1:0] = in_strb;
    lane_strb_s = lane_base_s << (slot_s * SIN);
    merged_s    = acc_r | lane_strb_s;
    closing_s   = (slot_s == LAST_SLOT) | in_last;
  end

  // Accumulator and registered output stage.
  always_ff @(posedge ACLK) begin
    if (sysReset) begin
      acc_r        <= {SOUT{1'b0}};
      out_valid    <= 1'b0;
      out_strb     <= {SOUT{1'b0}};
      out_mask_bit <= {DATA_WIDTH_OUT{1'b0}};
      out_last     <= 1'b0;
    end else if (accept_s && closing_s) begin
      // A closing beat loads the new word even while the old one drains.
      acc_r        <= {SOUT{1'b0}};
      out_valid    <= 1'b1;
      out_strb     <= merged_s;
      out_mask_bit <= expand_mask(merged_s);
      out_last     <= in_last;
    end else begin
      if (accept_s) begin
        acc_r <= merged_s;
      end else begin
        acc_r <= acc_r;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule
